// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the fetch side and the data side of
// a pipeline. Each grant is a single access. The access stays on the Mem* port
// until MemRdy. A one-cycle RESP state then follows, which pulses the matching
// Valid. Data requests win over fetch requests.
//
// Optional feature (macro ARB_STARVE_GUARD_EN):
//   Adds a 3-bit starvation counter. After four consecutive data grants made
//   while fetch was waiting, the next contested grant goes to fetch.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   IReq/IAddr          fetch request (held until IValid) and address
//   IRdata/IValid       fetched word, one-cycle completion pulse
//   DReq/DWe/DAddr      data request (held until DValid), store flag, address
//   DWdata/DByteEn      store data and byte enables
//   DRdata/DValid       load data (unchanged on stores), completion pulse
//   StallF/StallM       combinational stalls for the fetch and memory stages
//   MemReq/MemWE/MemAddr/MemWData/MemBE   registered memory request
//   MemRData/MemRdy     memory read data, access complete this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   output logic [31:0] IRdata,
   output logic        IValid,
   input  logic        DReq,
   input  logic        DWe,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWdata,
   input  logic [3:0]  DByteEn,
   output logic [31:0] DRdata,
   output logic        DValid,
   output logic        StallF,
   output logic        StallM,
   output logic        MemReq,
   output logic        MemWE,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic [3:0]  MemBE,
   input  logic [31:0] MemRData,
   input  logic        MemRdy
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        ivalid_q, ivalid_d;
   logic        dvalid_q, dvalid_d;
   logic        fetch_first;

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0]  starve_q, starve_d;

   // Fetch overrides data priority only when it has been passed over four times.
   assign fetch_first = IReq && (starve_q == 3'd4);
`else
   assign fetch_first = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      irdata_d    = irdata_q;
      drdata_d    = drdata_q;
      ivalid_d    = 1'b0;
      dvalid_d    = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_d    = starve_q;
`endif
      case (state_q)
         IDLE: begin
            if (DReq && !fetch_first) begin
               mem_req_d   = 1'b1;
               mem_we_d    = DWe;
               mem_addr_d  = DAddr;
               mem_wdata_d = DWdata;
               mem_be_d    = DByteEn;
               state_d     = DBUSY;
`ifdef ARB_STARVE_GUARD_EN
               // Only data grants that made fetch wait count toward starvation.
               if (IReq)
                  starve_d = (starve_q == 3'd4) ? 3'd4 : starve_q + 3'd1;
               else
                  starve_d = 3'd0;
`endif
            end else if (IReq) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = IAddr;
               mem_be_d   = 4'b1111;
               state_d    = IBUSY;
`ifdef ARB_STARVE_GUARD_EN
               starve_d   = 3'd0;
`endif
            end
         end
         IBUSY, DBUSY: begin
            if (MemRdy) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = RESP;
               if (state_q == IBUSY) begin
                  ivalid_d = 1'b1;
                  irdata_d = MemRData;
               end else begin
                  dvalid_d = 1'b1;
                  // Stores leave the last load result untouched.
                  if (!mem_we_q)
                     drdata_d = MemRData;
               end
            end
         end
         // A single dead cycle lets the pipeline drop the request it just got
         // served before the arbiter looks at the request lines again.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         irdata_q    <= 32'h0;
         drdata_q    <= 32'h0;
         ivalid_q    <= 1'b0;
         dvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         irdata_q    <= irdata_d;
         drdata_q    <= drdata_d;
         ivalid_q    <= ivalid_d;
         dvalid_q    <= dvalid_d;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   always_ff @(posedge clk) begin
      if (reset)
         starve_q <= 3'd0;
      else
         starve_q <= starve_d;
   end
`endif

   assign MemReq   = mem_req_q;
   assign MemWE    = mem_we_q;
   assign MemAddr  = mem_addr_q;
   assign MemWData = mem_wdata_q;
   assign MemBE    = mem_be_q;
   assign IRdata   = irdata_q;
   assign DRdata   = drdata_q;
   assign IValid   = ivalid_q;
   assign DValid   = dvalid_q;

   assign StallF = IReq & ~ivalid_q;
   assign StallM = DReq & ~dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        IReq;
   logic [31:0] IAddr;
   logic [31:0] IRdata;
   logic        IValid;
   logic        DReq;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWdata;
   logic [3:0]  DByteEn;
   logic [31:0] DRdata;
   logic        DValid;
   logic        StallF;
   logic        StallM;
   logic        MemReq;
   logic        MemWE;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [3:0]  MemBE;
   logic [31:0] MemRData;
   logic        MemRdy;

   int n_assert = 0;
   int n_fail   = 0;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .IReq     (IReq),
      .IAddr    (IAddr),
      .IRdata   (IRdata),
      .IValid   (IValid),
      .DReq     (DReq),
      .DWe      (DWe),
      .DAddr    (DAddr),
      .DWdata   (DWdata),
      .DByteEn  (DByteEn),
      .DRdata   (DRdata),
      .DValid   (DValid),
      .StallF   (StallF),
      .StallM   (StallM),
      .MemReq   (MemReq),
      .MemWE    (MemWE),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemBE    (MemBE),
      .MemRData (MemRData),
      .MemRdy   (MemRdy)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; the caller drives inputs
   // here and checks after a further #1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      IReq = 1'b0; IAddr = 32'h0; DReq = 1'b0; DWe = 1'b0; DAddr = 32'h0;
      DWdata = 32'h0; DByteEn = 4'h0; MemRData = 32'h0; MemRdy = 1'b0;
      tick(); tick(); #1;
      n_assert++; if (MemReq !== 1'b0) begin n_fail++; $display("FAIL reset_memreq: got %h expected 0", MemReq); end
      n_assert++; if (MemWE !== 1'b0) begin n_fail++; $display("FAIL reset_memwe: got %h expected 0", MemWE); end
      n_assert++; if (IValid !== 1'b0 || DValid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b expected 00", IValid, DValid); end
      n_assert++; if (MemAddr !== 32'h0 || MemWData !== 32'h0) begin n_fail++; $display("FAIL reset_memaddr_wdata: got %h/%h expected 0/0", MemAddr, MemWData); end
      n_assert++; if (MemBE !== 4'h0) begin n_fail++; $display("FAIL reset_membe: got %h expected 0", MemBE); end
      n_assert++; if (IRdata !== 32'h0 || DRdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", IRdata, DRdata); end
      n_assert++; if (StallF !== 1'b0 || StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stalls: got %b%b expected 00", StallF, StallM); end
      reset = 1'b0;
      MemRdy = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      MemRdy = 1'b1; MemRData = 32'hE3A01001;
      // cycle 0
      tick(); IReq = 1'b1; IAddr = 32'h100; #1;
      n_assert++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL fetch_stallf_c0: got %b expected 1", StallF); end
      n_assert++; if (MemReq !== 1'b0) begin n_fail++; $display("FAIL fetch_memreq_c0: got %b expected 0", MemReq); end
      // cycle 1
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h100) begin n_fail++; $display("FAIL fetch_mem_c1: got req=%b addr=%h expected req=1 addr=00000100", MemReq, MemAddr); end
      n_assert++; if (MemWE !== 1'b0 || MemBE !== 4'hF) begin n_fail++; $display("FAIL fetch_we_be_c1: got we=%b be=%h expected we=0 be=f", MemWE, MemBE); end
      n_assert++; if (StallF !== 1'b1 || IValid !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c1: got stallf=%b ivalid=%b expected 1/0", StallF, IValid); end
      // cycle 2
      tick(); #1;
      n_assert++; if (IValid !== 1'b1 || IRdata !== 32'hE3A01001) begin n_fail++; $display("FAIL fetch_resp_c2: got ivalid=%b irdata=%h expected 1/e3a01001", IValid, IRdata); end
      n_assert++; if (StallF !== 1'b0 || MemReq !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c2: got stallf=%b memreq=%b expected 0/0", StallF, MemReq); end
      IReq = 1'b0;
      // cycle 3
      tick(); #1;
      n_assert++; if (IValid !== 1'b0 || MemReq !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_c3: got ivalid=%b memreq=%b expected 0/0", IValid, MemReq); end
   endtask

   task automatic test_priority();
      MemRdy = 1'b1; MemRData = 32'hCAFEF00D;
      // cycle 0: both requests together
      tick();
      IReq = 1'b1; IAddr = 32'h104;
      DReq = 1'b1; DWe = 1'b1; DAddr = 32'h200; DWdata = 32'hDEADBEEF; DByteEn = 4'b0011;
      #1;
      n_assert++; if (StallF !== 1'b1 || StallM !== 1'b1) begin n_fail++; $display("FAIL prio_stalls_c0: got %b%b expected 11", StallF, StallM); end
      // cycle 1: store on the port
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemWE !== 1'b1 || MemAddr !== 32'h200) begin n_fail++; $display("FAIL prio_store_c1: got req=%b we=%b addr=%h expected 1/1/00000200", MemReq, MemWE, MemAddr); end
      n_assert++; if (MemWData !== 32'hDEADBEEF || MemBE !== 4'b0011) begin n_fail++; $display("FAIL prio_store_data_c1: got %h be=%h expected deadbeef be=3", MemWData, MemBE); end
      // cycle 2: store completes, load data untouched
      tick(); #1;
      n_assert++; if (DValid !== 1'b1 || DRdata !== 32'h0 || StallM !== 1'b0) begin n_fail++; $display("FAIL prio_store_resp_c2: got dvalid=%b drdata=%h stallm=%b expected 1/00000000/0", DValid, DRdata, StallM); end
      n_assert++; if (MemReq !== 1'b0 || MemWE !== 1'b0) begin n_fail++; $display("FAIL prio_memreq_c2: got req=%b we=%b expected 0/0", MemReq, MemWE); end
      DReq = 1'b0;
      // cycle 3: idle, fetch granted at end of this cycle
      tick(); #1;
      n_assert++; if (MemReq !== 1'b0 || DValid !== 1'b0) begin n_fail++; $display("FAIL prio_idle_c3: got req=%b dvalid=%b expected 0/0", MemReq, DValid); end
      // cycle 4: fetch on the port
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h104 || MemWE !== 1'b0 || MemBE !== 4'hF) begin n_fail++; $display("FAIL prio_fetch_c4: got req=%b addr=%h we=%b be=%h expected 1/00000104/0/f", MemReq, MemAddr, MemWE, MemBE); end
      // cycle 5
      tick(); #1;
      n_assert++; if (IValid !== 1'b1 || IRdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL prio_fetch_resp_c5: got ivalid=%b irdata=%h expected 1/cafef00d", IValid, IRdata); end
      IReq = 1'b0;
      tick();
   endtask

   task automatic test_wait_load();
      MemRdy = 1'b0; MemRData = 32'h12345678;
      tick(); DReq = 1'b1; DWe = 1'b0; DAddr = 32'h300; DByteEn = 4'hF; #1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 2) DAddr = 32'h3FC;
         #1;
         n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h300 || DValid !== 1'b0) begin n_fail++; $display("FAIL wait_hold_c%0d: got req=%b addr=%h dvalid=%b expected 1/00000300/0", c, MemReq, MemAddr, DValid); end
      end
      // cycle 4: memory ready
      tick(); MemRdy = 1'b1; #1;
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h300 || DValid !== 1'b0) begin n_fail++; $display("FAIL wait_rdy_c4: got req=%b addr=%h dvalid=%b expected 1/00000300/0", MemReq, MemAddr, DValid); end
      // cycle 5
      tick(); #1;
      n_assert++; if (DValid !== 1'b1 || DRdata !== 32'h12345678 || MemReq !== 1'b0) begin n_fail++; $display("FAIL wait_resp_c5: got dvalid=%b drdata=%h req=%b expected 1/12345678/0", DValid, DRdata, MemReq); end
      DReq = 1'b0;
      tick();
   endtask

   task automatic test_store_hold();
      MemRdy = 1'b1; MemRData = 32'hFFFFFFFF;
      tick(); DReq = 1'b1; DWe = 1'b1; DAddr = 32'h204; DWdata = 32'h11223344; DByteEn = 4'b1100; #1;
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemWE !== 1'b1 || MemBE !== 4'b1100 || MemWData !== 32'h11223344) begin n_fail++; $display("FAIL store_issue: got req=%b we=%b be=%h wdata=%h expected 1/1/c/11223344", MemReq, MemWE, MemBE, MemWData); end
      tick(); #1;
      n_assert++; if (DValid !== 1'b1 || DRdata !== 32'h12345678) begin n_fail++; $display("FAIL store_resp: got dvalid=%b drdata=%h expected 1/12345678", DValid, DRdata); end
      DReq = 1'b0;
      tick(); #1;
      n_assert++; if (DValid !== 1'b0 || DRdata !== 32'h12345678) begin n_fail++; $display("FAIL store_pulse_end: got dvalid=%b drdata=%h expected 0/12345678", DValid, DRdata); end
   endtask

   task automatic test_reset_abort();
      MemRdy = 1'b0; MemRData = 32'h55AA55AA;
      tick(); DReq = 1'b1; DWe = 1'b0; DAddr = 32'h400; #1;
      // cycle 1: in DBUSY, reset arrives and the pipeline drops the request
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h400) begin n_fail++; $display("FAIL abort_busy_c1: got req=%b addr=%h expected 1/00000400", MemReq, MemAddr); end
      reset = 1'b1; DReq = 1'b0;
      // cycle 2: abandoned; a fresh fetch is presented to prove IDLE
      tick(); reset = 1'b0; MemRdy = 1'b1; IReq = 1'b1; IAddr = 32'h500; #1;
      n_assert++; if (MemReq !== 1'b0 || DValid !== 1'b0 || MemAddr !== 32'h0) begin n_fail++; $display("FAIL abort_c2: got req=%b dvalid=%b addr=%h expected 0/0/00000000", MemReq, DValid, MemAddr); end
      tick(); #1;
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h500 || DValid !== 1'b0) begin n_fail++; $display("FAIL abort_regrant_c3: got req=%b addr=%h dvalid=%b expected 1/00000500/0", MemReq, MemAddr, DValid); end
      tick(); #1;
      n_assert++; if (IValid !== 1'b1 || DValid !== 1'b0) begin n_fail++; $display("FAIL abort_resp_c4: got ivalid=%b dvalid=%b expected 1/0", IValid, DValid); end
      IReq = 1'b0;
      tick(); #1;
      n_assert++; if (DValid !== 1'b0) begin n_fail++; $display("FAIL abort_no_dvalid_c5: got %b expected 0", DValid); end
   endtask

   task automatic test_back_to_back();
      int          grants;
      int          waited;
      logic        prev_req;
      logic [31:0] exp_addr;
      grants = 0;
      MemRdy = 1'b1; MemRData = 32'h0BADF00D;
      tick();
      IReq = 1'b1; IAddr = 32'h600;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h700; DByteEn = 4'hF;
      prev_req = MemReq;
      for (int c = 0; c < 60 && grants < 6; c++) begin
         tick(); #1;
         if (MemReq && !prev_req) begin
            grants++;
`ifdef ARB_STARVE_GUARD_EN
            exp_addr = (grants == 5) ? 32'h600 : 32'h700;
`else
            exp_addr = 32'h700;
`endif
            n_assert++; if (MemAddr !== exp_addr) begin n_fail++; $display("FAIL b2b_grant%0d: got addr=%h expected %h", grants, MemAddr, exp_addr); end
         end
         if (IValid) IReq = 1'b0;
         prev_req = MemReq;
      end
      n_assert++; if (grants != 6) begin n_fail++; $display("FAIL b2b_grant_count: got %0d expected 6", grants); end
      waited = 0;
      while (!DValid && waited < 10) begin tick(); #1; waited++; end
      n_assert++; if (DValid !== 1'b1) begin n_fail++; $display("FAIL b2b_last_dvalid: got %b expected 1", DValid); end
      DReq = 1'b0;
`ifndef ARB_STARVE_GUARD_EN
      waited = 0;
      tick(); #1;
      while (!MemReq && waited < 10) begin tick(); #1; waited++; end
      n_assert++; if (MemReq !== 1'b1 || MemAddr !== 32'h600) begin n_fail++; $display("FAIL b2b_fetch_after_drop: got req=%b addr=%h expected 1/00000600", MemReq, MemAddr); end
      tick(); #1;
      n_assert++; if (IValid !== 1'b1) begin n_fail++; $display("FAIL b2b_fetch_ivalid: got %b expected 1", IValid); end
`endif
      IReq = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_wait_load();
      test_store_hold();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-high reset:
  - clk  in  1  clock; all state updates on the rising edge.
  - reset  in  1  synchronous, active-high reset.
- REQ-002 The block SHALL provide the fetch-side ports:
  - IReq  in  1  fetch request; held until IValid.
  - IAddr  in  32  fetch address.
  - IRdata  out  32  fetched word.
  - IValid  out  1  one-cycle fetch completion pulse.
- REQ-003 The block SHALL provide the data-side ports:
  - DReq  in  1  load/store request; held until DValid.
  - DWe  in  1  1 = store, 0 = load.
  - DAddr  in  32  data address.
  - DWdata  in  32  store data.
  - DByteEn  in  4  store byte enables.
  - DRdata  out  32  load data.
  - DValid  out  1  one-cycle data completion pulse.
- REQ-004 The block SHALL provide the pipeline stall ports:
  - StallF  out  1  fetch stage stall.
  - StallM  out  1  memory stage stall.
- REQ-005 The block SHALL provide the memory-side ports:
  - MemReq  out  1  access request.
  - MemWE  out  1  write enable.
  - MemAddr  out  32  address.
  - MemWData  out  32  write data.
  - MemBE  out  4  byte enables.
  - MemRData  in  32  read data.
  - MemRdy  in  1  access complete this cycle.

Function
- REQ-006 The FSM SHALL have the states IDLE, IBUSY, DBUSY and RESP.
- REQ-007 In IDLE, the arbiter SHALL grant as follows:
  - DReq=1: capture DWe/DAddr/DWdata/DByteEn into the Mem* registers; MemReq=1; next state DBUSY.
  - Else IReq=1: MemAddr=IAddr, MemWE=0, MemBE=4'b1111, MemReq=1; next state IBUSY.
  - Else stay in IDLE.
  - DReq has priority over IReq.
- REQ-008 In IBUSY/DBUSY, MemReq and all Mem* outputs SHALL stay stable until MemRdy=1 is sampled.
- REQ-009 On the edge at which MemRdy=1 is sampled in IBUSY/DBUSY:
  - MemReq and MemWE go to 0.
  - The FSM goes to RESP.
  - The matching Valid is registered high for exactly the RESP cycle.
- REQ-010 On completion, IRdata SHALL load MemRData (IBUSY), and DRdata SHALL load MemRData on loads only.
  - DRdata SHALL hold its previous value on stores; DValid still pulses on stores.
- REQ-011 RESP SHALL last exactly one cycle, perform no arbitration, and always return to IDLE.
  - This prevents re-granting a request the pipeline is dropping.
- REQ-012 Minimum latency with MemRdy tied to 1:
  - Request seen in cycle 0.
  - MemReq high in cycle 1.
  - Valid in cycle 2.
  - Next grant possible at the end of cycle 3.
- REQ-013 Each additional cycle of MemRdy=0 SHALL add exactly one cycle of latency.
- REQ-014 StallF = IReq & ~IValid and StallM = DReq & ~DValid, both combinational.
- REQ-015 MemRdy SHALL be ignored in IDLE and RESP.
- REQ-016 Request inputs that change while their own access is in flight SHALL be ignored; only values captured at grant are used.

Reset
- REQ-017 On reset:
  - The FSM SHALL go to IDLE.
  - MemReq, MemWE, IValid and DValid SHALL be 0.
  - MemAddr, MemWData, IRdata and DRdata SHALL be 32'h0, and MemBE 4'h0.
  - The starvation counter SHALL clear.
- REQ-018 Reset during IBUSY/DBUSY SHALL abandon the access:
  - MemReq=0 in the next cycle.
  - No Valid pulse is generated for the abandoned access.

Configuration
- REQ-019 With ARB_STARVE_GUARD_EN defined, a 3-bit counter SHALL track grants:
  - It counts consecutive data grants made while IReq=1.
  - At count 4, the next IDLE cycle with both requests high SHALL grant fetch.
  - The counter clears on any fetch grant, and on a data grant made with IReq=0.
- REQ-020 Without ARB_STARVE_GUARD_EN, no counter SHALL exist and DReq SHALL always win (REQ-007).

Verification
- REQ-021 Fetch, MemRdy=1, IAddr=0x100, MemRData=0xE3A01001:
  - MemReq=1 with MemAddr=0x100 in cycle 1.
  - IValid=1 with IRdata=0xE3A01001 in cycle 2.
  - StallF=1 in cycles 0-1 and 0 in cycle 2.
- REQ-022 IReq and DReq raised in the same cycle, store DAddr=0x200, DWdata=0xDEADBEEF, DByteEn=4'b0011:
  - The store is issued first, with MemWE=1 and MemBE=0011.
  - The fetch MemReq rises 3 cycles later.
- REQ-023 Load DAddr=0x300 with MemRdy low for 3 cycles, MemRData=0x12345678:
  - MemAddr stays at 0x300 throughout.
  - DValid=1 with DRdata=0x12345678 in the cycle after MemRdy.
- REQ-024 Reset asserted during DBUSY:
  - Next cycle: MemReq=0 and the FSM is in IDLE.
  - No DValid is ever produced for that access.
- REQ-025 DReq re-presented back-to-back with IReq held at 1:
  - With ARB_STARVE_GUARD_EN: the 5th grant is the fetch.
  - Without it: the fetch is granted only after DReq drops.
- REQ-026 Store completion:
  - DValid pulses for one cycle.
  - DRdata keeps its previous value (0x12345678 from REQ-023).
